// File: rtl/logic_gate_array_sync.sv
// logic_gate_array_sync: CHANNELS independent INPUTS-wide gates with a run-time
// selectable function (NAND/AND/NOR/OR), a per-channel transport delay line of
// DELAY registers and an inertial filter that passes a change only after it has
// persisted FILTER+1 consecutive enabled edges.
// Optional build macro GATE_GLITCH_CNT_EN adds a per-channel 8-bit saturating
// count of suppressed pulses on output GLITCH.
module logic_gate_array_sync #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned INPUTS   = 4,
   parameter int unsigned DELAY    = 2,
   parameter int unsigned FILTER   = 1
) (
   input  logic                         CLK,
   input  logic                         CLR,
   input  logic                         EN,
   input  logic [1:0]                   MODE,
   input  logic [CHANNELS*INPUTS-1:0]   D,
   output logic [CHANNELS-1:0]          Y,
   output logic [CHANNELS-1:0]          CHG
`ifdef GATE_GLITCH_CNT_EN
   ,
   output logic [CHANNELS*8-1:0]        GLITCH
`endif
);

   localparam int unsigned CNT_W  = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
   localparam int          DLY_N  = int'(DELAY);
   localparam int          CHAN_N = int'(CHANNELS);

   logic [CHANNELS-1:0] f_c;
   logic [CHANNELS-1:0] cand_c;
   logic [CNT_W-1:0]    cnt_q [CHANNELS];

   // Combinational gate function of each channel's input slice
   always_comb begin
      f_c = '0;
      for (int c = 0; c < CHAN_N; c++) begin
         unique case (MODE)
            2'b00:   f_c[c] = ~(&D[c*INPUTS +: INPUTS]);
            2'b01:   f_c[c] =   &D[c*INPUTS +: INPUTS];
            2'b10:   f_c[c] = ~(|D[c*INPUTS +: INPUTS]);
            default: f_c[c] =   |D[c*INPUTS +: INPUTS];
         endcase
      end
   end

   generate
      if (DELAY > 0) begin : g_dly
         logic [CHANNELS-1:0] dly_q [DELAY];

         // Transport delay line; stages reset to 1 to match the NAND idle output
         always_ff @(posedge CLK or negedge CLR) begin
            if (!CLR) begin
               for (int k = 0; k < DLY_N; k++) dly_q[k] <= '1;
            end else if (EN) begin
               dly_q[0] <= f_c;
               for (int k = 1; k < DLY_N; k++) dly_q[k] <= dly_q[k-1];
            end
         end

         assign cand_c = dly_q[DELAY-1];
      end else begin : g_nodly
         assign cand_c = f_c;
      end
   endgenerate

   // Inertial filter: a differing candidate must persist FILTER+1 edges
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         Y   <= '1;
         CHG <= '0;
         for (int c = 0; c < CHAN_N; c++) cnt_q[c] <= '0;
      end else if (!EN) begin
         CHG <= '0;
      end else begin
         for (int c = 0; c < CHAN_N; c++) begin
            if (cand_c[c] == Y[c]) begin
               cnt_q[c] <= '0;
               CHG[c]   <= 1'b0;
            end else if (cnt_q[c] == CNT_W'(FILTER)) begin
               Y[c]     <= cand_c[c];
               cnt_q[c] <= '0;
               CHG[c]   <= 1'b1;
            end else begin
               cnt_q[c] <= cnt_q[c] + CNT_W'(1);
               CHG[c]   <= 1'b0;
            end
         end
      end
   end

`ifdef GATE_GLITCH_CNT_EN
   // Saturating count of pulses the filter swallowed (counter cleared from nonzero)
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         GLITCH <= '0;
      end else if (EN) begin
         for (int c = 0; c < CHAN_N; c++) begin
            if ((cand_c[c] == Y[c]) && (cnt_q[c] != '0) &&
                (GLITCH[c*8 +: 8] != 8'hFF)) begin
               GLITCH[c*8 +: 8] <= GLITCH[c*8 +: 8] + 8'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_logic_gate_array_sync.sv
// Self-checking bench for logic_gate_array_sync (CHANNELS=2, INPUTS=4, DELAY=2,
// FILTER=2). Directed scenarios plus randomized traffic against a queue-based
// behavioural model.
module tb_logic_gate_array_sync;

   localparam int unsigned CH = 2;
   localparam int unsigned IN = 4;
   localparam int unsigned DL = 2;
   localparam int unsigned FL = 2;

   logic          CLK;
   logic          CLR;
   logic          EN;
   logic [1:0]    MODE;
   logic [CH*IN-1:0] D;
   logic [CH-1:0] Y;
   logic [CH-1:0] CHG;
`ifdef GATE_GLITCH_CNT_EN
   logic [CH*8-1:0] GLITCH;
`endif

   int checks   = 0;
   int failures = 0;

   logic_gate_array_sync #(
      .CHANNELS(CH), .INPUTS(IN), .DELAY(DL), .FILTER(FL)
   ) dut (
      .CLK   (CLK),
      .CLR   (CLR),
      .EN    (EN),
      .MODE  (MODE),
      .D     (D),
      .Y     (Y),
      .CHG   (CHG)
`ifdef GATE_GLITCH_CNT_EN
      ,
      .GLITCH(GLITCH)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural model ----------------
   logic [CH-1:0] m_hist [$];
   logic [CH-1:0] m_y;
   logic [CH-1:0] m_chg;
   int            m_run    [CH];
   int            m_glitch [CH];

   function automatic logic gate_fn(input logic [1:0] mode, input logic [IN-1:0] s);
      int  ones;
      logic all_hi, any_hi;
      ones   = $countones(s);
      all_hi = (ones == int'(IN));
      any_hi = (ones > 0);
      case (mode)
         2'd0:    return !all_hi;
         2'd1:    return all_hi;
         2'd2:    return !any_hi;
         default: return any_hi;
      endcase
   endfunction

   task automatic model_reset();
      m_hist.delete();
      for (int i = 0; i < int'(DL); i++) m_hist.push_front('1);
      m_y   = '1;
      m_chg = '0;
      for (int c = 0; c < int'(CH); c++) begin
         m_run[c]    = 0;
         m_glitch[c] = 0;
      end
   endtask

   // One rising edge: the value f seen now emerges from the history DL edges later
   task automatic model_step(input logic en, input logic [1:0] mode, input logic [CH*IN-1:0] d);
      logic [CH-1:0] f_now, cand;
      logic [IN-1:0] s;
      if (!en) begin
         m_chg = '0;
         return;
      end
      for (int c = 0; c < int'(CH); c++) begin
         s = d[c*IN +: IN];
         f_now[c] = gate_fn(mode, s);
      end
      m_hist.push_front(f_now);
      cand = m_hist.pop_back();
      for (int c = 0; c < int'(CH); c++) begin
         m_chg[c] = 1'b0;
         if (cand[c] == m_y[c]) begin
            if (m_run[c] > 0 && m_glitch[c] < 255) m_glitch[c]++;
            m_run[c] = 0;
         end else begin
            m_run[c]++;
            if (m_run[c] == int'(FL) + 1) begin
               m_y[c]   = cand[c];
               m_chg[c] = 1'b1;
               m_run[c] = 0;
            end
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      D    = '0;
      MODE = 2'b00;
      EN   = 1'b1;
      CLR  = 1'b0;
      @(negedge CLK);
      CLR = 1'b1;
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      D = '0; MODE = 2'b00; EN = 1'b1;
      #2 CLR = 1'b0;
      #1;
      checks++;
      if (Y !== 2'b11 || CHG !== 2'b00) begin
         failures++;
         $display("FAIL reset_assert: Y=%b CHG=%b required Y=11 CHG=00", Y, CHG);
      end
      @(negedge CLK);
      CLR = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (Y !== 2'b11 || CHG !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle edge %0d: Y=%b CHG=%b required Y=11 CHG=00", i, Y, CHG);
         end
      end
   endtask

   task automatic test_nand_propagation();
      apply_reset();
      D[3:0] = 4'hF;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (Y !== 2'b11 || CHG !== 2'b00) begin
            failures++;
            $display("FAIL nand_early edge k+%0d: Y=%b CHG=%b required Y=11 CHG=00", i, Y, CHG);
         end
      end
      tick();
      checks++;
      if (Y !== 2'b10 || CHG !== 2'b01) begin
         failures++;
         $display("FAIL nand_fall at k+4: Y=%b CHG=%b required Y=10 CHG=01", Y, CHG);
      end
      tick();
      checks++;
      if (Y !== 2'b10 || CHG !== 2'b00) begin
         failures++;
         $display("FAIL nand_chg_clear at k+5: Y=%b CHG=%b required Y=10 CHG=00", Y, CHG);
      end
      D[3:0] = 4'h0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (Y !== 2'b10 || CHG !== 2'b00) begin
            failures++;
            $display("FAIL nand_return_hold edge %0d: Y=%b CHG=%b required Y=10 CHG=00", i, Y, CHG);
         end
      end
      tick();
      checks++;
      if (Y !== 2'b11 || CHG !== 2'b01) begin
         failures++;
         $display("FAIL nand_rise: Y=%b CHG=%b required Y=11 CHG=01", Y, CHG);
      end
   endtask

   task automatic test_glitch_filter();
      int low_cycles;
      int chg_pulses;
      apply_reset();
      D[7:4] = 4'hF;
      tick();
      tick();
      D[7:4] = 4'h0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (Y !== 2'b11 || CHG !== 2'b00) begin
            failures++;
            $display("FAIL glitch_short edge %0d: Y=%b CHG=%b required Y=11 CHG=00", i, Y, CHG);
         end
      end
`ifdef GATE_GLITCH_CNT_EN
      checks++;
      if (GLITCH !== 16'h0100) begin
         failures++;
         $display("FAIL glitch_count: GLITCH=%h required 0100", GLITCH);
      end
`endif
      low_cycles = 0;
      chg_pulses = 0;
      D[7:4] = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (!Y[1]) low_cycles++;
         if (CHG[1]) chg_pulses++;
      end
      D[7:4] = 4'h0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (!Y[1]) low_cycles++;
         if (CHG[1]) chg_pulses++;
      end
      checks++;
      if (low_cycles != 3) begin
         failures++;
         $display("FAIL pulse3_width: Y[1] low for %0d cycles required 3", low_cycles);
      end
      checks++;
      if (chg_pulses != 2) begin
         failures++;
         $display("FAIL pulse3_chg: CHG[1] pulses=%0d required 2", chg_pulses);
      end
      checks++;
      if (Y !== 2'b11) begin
         failures++;
         $display("FAIL pulse3_end: Y=%b required 11", Y);
      end
   endtask

   task automatic test_mode_switch();
      apply_reset();
      MODE = 2'b01;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (Y !== 2'b11 || CHG !== 2'b00) begin
            failures++;
            $display("FAIL mode_hold edge %0d: Y=%b CHG=%b required Y=11 CHG=00", i, Y, CHG);
         end
      end
      tick();
      checks++;
      if (Y !== 2'b00 || CHG !== 2'b11) begin
         failures++;
         $display("FAIL mode_and: Y=%b CHG=%b required Y=00 CHG=11", Y, CHG);
      end
      MODE = 2'b11;
      D    = 8'h01;
      repeat (6) tick();
      checks++;
      if (Y !== 2'b01) begin
         failures++;
         $display("FAIL mode_or: Y=%b required 01", Y);
      end
   endtask

   task automatic test_enable_freeze();
      apply_reset();
      D[3:0] = 4'hF;
      tick();
      tick();
      EN = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (Y !== 2'b11 || CHG !== 2'b00) begin
            failures++;
            $display("FAIL freeze_hold %0d: Y=%b CHG=%b required Y=11 CHG=00", i, Y, CHG);
         end
      end
      EN = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (Y !== 2'b11) begin
            failures++;
            $display("FAIL freeze_resume_early %0d: Y=%b required 11", i, Y);
         end
      end
      tick();
      checks++;
      if (Y !== 2'b10 || CHG !== 2'b01) begin
         failures++;
         $display("FAIL freeze_resume_third: Y=%b CHG=%b required Y=10 CHG=01", Y, CHG);
      end
   endtask

   task automatic test_reset_mid_propagation();
      apply_reset();
      D[3:0] = 4'hF;
      repeat (6) tick();
      D[7:4] = 4'hF;
      tick();
      tick();
      tick();
      checks++;
      if (Y !== 2'b10) begin
         failures++;
         $display("FAIL midrst_pre: Y=%b required 10", Y);
      end
      #1 CLR = 1'b0;
      #1;
      checks++;
      if (Y !== 2'b11 || CHG !== 2'b00) begin
         failures++;
         $display("FAIL midrst_async: Y=%b CHG=%b required Y=11 CHG=00", Y, CHG);
      end
      D = '0;
      @(negedge CLK);
      CLR = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (Y !== 2'b11 || CHG !== 2'b00) begin
            failures++;
            $display("FAIL midrst_after %0d: Y=%b CHG=%b required Y=11 CHG=00", i, Y, CHG);
         end
      end
   endtask

   task automatic test_random();
      logic [IN-1:0] s;
      apply_reset();
      model_reset();
      model_step(1'b1, 2'b00, '0);
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < int'(CH); c++) begin
            if ($urandom_range(0, 2) == 0) begin
               s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'(($urandom_range(0, 1) == 0) ? 0 : $urandom);
               D[c*IN +: IN] = s;
            end
         end
         if ($urandom_range(0, 39) == 0) MODE = 2'($urandom);
         EN = ($urandom_range(0, 9) != 0);
         tick();
         model_step(EN, MODE, D);
         checks++;
         if (Y !== m_y || CHG !== m_chg) begin
            failures++;
            $display("FAIL random cycle %0d: Y=%b CHG=%b required Y=%b CHG=%b", i, Y, CHG, m_y, m_chg);
         end
`ifdef GATE_GLITCH_CNT_EN
         checks++;
         if (GLITCH !== {8'(m_glitch[1]), 8'(m_glitch[0])}) begin
            failures++;
            $display("FAIL random_glitch cycle %0d: GLITCH=%h required %h", i, GLITCH,
                     {8'(m_glitch[1]), 8'(m_glitch[0])});
         end
`endif
      end
      EN = 1'b1;
   endtask

   initial begin
      CLR  = 1'b1;
      EN   = 1'b1;
      MODE = 2'b00;
      D    = '0;
      test_reset();
      test_nand_propagation();
      test_glitch_filter();
      test_mode_switch();
      test_enable_freeze();
      test_reset_mid_propagation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/logic_gate_array_sync.md
Name: logic_gate_array_sync

Overview:
Parametrised, clocked successor to the fixed dual 4-input NAND library part. It provides CHANNELS independent INPUTS-wide gates with a run-time selectable function. Each channel has a cycle-accurate transport delay line and an inertial glitch filter, so board-level gate timing is modelled synthesisably. The block is a drop-in for the 74LSXX library wherever registered, glitch-free gate outputs are needed.

Parameters:
CHANNELS, 2, number of independent gates (1..16)
INPUTS, 4, inputs per gate (2..16)
DELAY, 2, transport delay in clock cycles (0..15); 0 = no delay-line registers
FILTER, 1, inertial filter length; a candidate change must persist FILTER+1 consecutive edges to propagate (0..15)

Ports:
CLK  in  1  system clock, rising edge
CLR  in  1  asynchronous, active-low reset
EN  in  1  advance enable; low freezes all state
MODE  in  2  00 NAND, 01 AND, 10 NOR, 11 OR; common to all channels
D  in  CHANNELS*INPUTS  gate inputs; channel c uses D[c*INPUTS +: INPUTS]
Y  out  CHANNELS  registered gate outputs
CHG  out  CHANNELS  one-cycle pulse in the cycle Y[c] takes a new value

Behaviour:
- Reset: CLR low asynchronously forces Y = all 1s, CHG = 0, every delay stage = 1, and every filter counter = 0. Y=1 matches NAND with all-low inputs. Reset dominates EN.
- Per-channel function f[c] = MODE applied to the channel's slice of D. Evaluation is combinational.
- Delay line per channel: DELAY registers, stage1 <= f[c], stage k <= stage k-1. Candidate cand[c] = last stage, or f[c] when DELAY=0.
- Filter, per channel, evaluated on each rising edge while EN=1:
  - cand == Y: cnt <= 0, CHG <= 0.
  - cand != Y and cnt == FILTER: Y <= cand, cnt <= 0, CHG <= 1.
  - cand != Y and cnt < FILTER: cnt <= cnt+1, CHG <= 0.
- Latency: a stable change in D present before edge k appears on Y (with CHG pulse) at edge k+DELAY+FILTER.
- Glitch rule: a candidate pulse shorter than FILTER+1 cycles never reaches Y.
- Counter width is clog2(FILTER+1), minimum 1; the counter never exceeds FILTER.
- EN=0: delay stages, counters and Y all hold; CHG <= 0. Propagation resumes where it stopped.
- MODE change behaves exactly like a D change: it passes through the same delay and filter. There is no immediate output effect.
- After reset in AND/OR mode with all-zero inputs, Y moves to 0 after DELAY+FILTER+1 edges, with a CHG pulse. This is expected.
- Channels are fully independent. Simultaneous changes on several channels each produce their own CHG pulse.

Optional Feature:
GATE_GLITCH_CNT_EN
- Defined: adds output GLITCH, width CHANNELS*8, one 8-bit counter per channel. A channel's counter increments when its filter counter is cleared from a nonzero value because cand returned equal to Y, i.e. a suppressed pulse. Counters saturate at 255, reset to 0 on CLR, and hold while EN=0.
- Undefined: no GLITCH port and no counter logic.

Test Plan:
All scenarios use CHANNELS=2, INPUTS=4, DELAY=2, FILTER=2, giving latency 5 edges.
1. Reset: CLR=0 with D=0, MODE=00 -> Y=2'b11, CHG=0. Release CLR and wait 10 edges -> Y stays 11, CHG never asserts.
2. NAND propagation: ch0 slice set to 4'hF before edge k -> Y[0]=0 and CHG[0]=1 exactly at edge k+4. CHG[0]=0 at edge k+5. Y[1] and CHG[1] unchanged. Return slice to 4'h0 -> Y[0]=1 after 5 edges.
3. Glitch filter: ch1 slice 4'hF for 2 cycles then 4'h0 -> Y[1] stays 1, no CHG, GLITCH[15:8]=1 if enabled. A 3-cycle pulse -> Y[1]=0 for exactly 3 cycles, with two CHG[1] pulses.
4. Mode switch: D=0, MODE 00->01 before edge k -> Y goes 11->00 at edge k+4 with CHG=2'b11. MODE 11 with D[0]=1 -> Y[0]=1, Y[1]=0.
5. Enable freeze: drive the scenario 2 change, then EN=0 for 6 cycles starting after edge k+1 -> Y holds and CHG stays 0. After EN=1, Y[0] falls on the 3rd enabled edge.
6. Reset mid-propagation: assert CLR asynchronously between edges k+2 and k+3 of a pending change -> Y=11 and CHG=0 immediately, with no CLK edge. After release with D=0, no spurious transition occurs.
